// File: rtl/lcm_pkg.sv
// Shared types and constants for the layered colour mapper.
package lcm_pkg;

  localparam int unsigned N_SPR_DEF        = 4;
  localparam int unsigned COORD_W_DEF      = 10;
  localparam int unsigned BLINK_FRAMES_DEF = 16;

  typedef enum logic {
    SQUARE = 1'b0,
    CIRCLE = 1'b1
  } spr_mode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [7:0] BG_R      = 8'h3F;
  localparam logic [7:0] BG_G      = 8'h00;
  localparam logic [7:0] BG_B_BASE = 8'h7F;

  // Background blue darkens with the top seven bits of the column
  function automatic logic [7:0] bg_blue(input logic [6:0] x_hi);
    return BG_B_BASE - {1'b0, x_hi};
  endfunction

endpackage

// File: rtl/layered_color_mapper_sprite_hit.sv
// Combinational hit test of one sprite against a pixel, given signed offsets.
module sprite_hit
  import lcm_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEF
) (
  input  logic [COORD_W:0]   dx,
  input  logic [COORD_W:0]   dy,
  input  logic [COORD_W-1:0] s,
  input  spr_mode_t          mode,
  output logic               hit_c
);

  localparam int unsigned OFS_W = COORD_W + 1;
  localparam int unsigned SQ_W  = 2 * COORD_W + 3;

  logic [OFS_W-1:0] adx;
  logic [OFS_W-1:0] ady;
  logic [SQ_W-1:0]  dist_sq;
  logic [SQ_W-1:0]  rad_sq;

  // Offsets are two's complement; magnitude never exceeds 2^COORD_W-1
  always_comb begin
    adx     = dx[COORD_W] ? (~dx + OFS_W'(1)) : dx;
    ady     = dy[COORD_W] ? (~dy + OFS_W'(1)) : dy;
    dist_sq = SQ_W'(adx) * SQ_W'(adx) + SQ_W'(ady) * SQ_W'(ady);
    rad_sq  = SQ_W'(s) * SQ_W'(s);
    hit_c   = 1'b0;
    if (mode == CIRCLE) begin
      hit_c = (dist_sq <= rad_sq);
    end else begin
      hit_c = (adx <= OFS_W'(s)) && (ady <= OFS_W'(s));
    end
  end

endmodule

// File: rtl/layered_color_mapper.sv
// Two-stage pixel pipeline: per-frame sprite shadow, offsets, priority colour select.
module layered_color_mapper
  import lcm_pkg::*;
#(
  parameter int unsigned N_SPR        = N_SPR_DEF,
  parameter int unsigned COORD_W      = COORD_W_DEF,
  parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEF
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            frame_start,
  input  logic                            pix_valid,
  input  logic [COORD_W-1:0]              DrawX,
  input  logic [COORD_W-1:0]              DrawY,
  input  logic [N_SPR-1:0][COORD_W-1:0]   spr_x,
  input  logic [N_SPR-1:0][COORD_W-1:0]   spr_y,
  input  logic [N_SPR-1:0][COORD_W-1:0]   spr_s,
  input  logic [N_SPR-1:0]                spr_mode,
  input  logic [N_SPR-1:0]                spr_en,
  input  logic [N_SPR-1:0]                spr_blink,
  input  logic [N_SPR-1:0][23:0]          spr_rgb,
  output logic [7:0]                      VGA_R,
  output logic [7:0]                      VGA_G,
  output logic [7:0]                      VGA_B,
  output logic                            rgb_valid
);

  localparam int unsigned OFS_W = COORD_W + 1;
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [N_SPR-1:0][COORD_W-1:0] sh_x;
  logic [N_SPR-1:0][COORD_W-1:0] sh_y;
  logic [N_SPR-1:0][COORD_W-1:0] sh_s;
  logic [N_SPR-1:0]              sh_mode;
  logic [N_SPR-1:0]              sh_en;
  logic [N_SPR-1:0]              sh_blink;
  logic [N_SPR-1:0][23:0]        sh_rgb;
  logic [CNT_W-1:0]              frame_cnt;
  logic                          blink_phase;

  logic [N_SPR-1:0][OFS_W-1:0]   dx_c;
  logic [N_SPR-1:0][OFS_W-1:0]   dy_c;
  logic [N_SPR-1:0]              act_c;

  logic                          s1_valid;
  logic [N_SPR-1:0][OFS_W-1:0]   s1_dx;
  logic [N_SPR-1:0][OFS_W-1:0]   s1_dy;
  logic [N_SPR-1:0][COORD_W-1:0] s1_s;
  logic [N_SPR-1:0]              s1_mode;
  logic [N_SPR-1:0]              s1_act;
  logic [N_SPR-1:0][23:0]        s1_rgb;
  logic [7:0]                    s1_bg_b;

  logic [N_SPR-1:0]              hit_c;
  rgb_t                          sel_c;
  logic                          sel_found_c;

  // Shadow registers and blink counter change only on frame_start
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sh_x        <= '0;
      sh_y        <= '0;
      sh_s        <= '0;
      sh_mode     <= '0;
      sh_en       <= '0;
      sh_blink    <= '0;
      sh_rgb      <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      sh_x     <= spr_x;
      sh_y     <= spr_y;
      sh_s     <= spr_s;
      sh_mode  <= spr_mode;
      sh_en    <= spr_en;
      sh_blink <= spr_blink;
      sh_rgb   <= spr_rgb;
      if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  // One extra bit keeps offsets exact at the coordinate extremes
  always_comb begin
    dx_c  = '0;
    dy_c  = '0;
    act_c = '0;
    for (int unsigned i = 0; i < N_SPR; i++) begin
      dx_c[i]  = {1'b0, DrawX} - {1'b0, sh_x[i]};
      dy_c[i]  = {1'b0, DrawY} - {1'b0, sh_y[i]};
      act_c[i] = sh_en[i] & ~(blink_phase & sh_blink[i]);
    end
  end

  // Stage 1 carries a snapshot of the sprite state so a frame_start
  // arriving while the pixel is in flight cannot alter its result
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_s     <= '0;
      s1_mode  <= '0;
      s1_act   <= '0;
      s1_rgb   <= '0;
      s1_bg_b  <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_dx    <= dx_c;
      s1_dy    <= dy_c;
      s1_s     <= sh_s;
      s1_mode  <= sh_mode;
      s1_act   <= act_c;
      s1_rgb   <= sh_rgb;
      s1_bg_b  <= bg_blue(DrawX[COORD_W-1 -: 7]);
    end
  end

  for (genvar g = 0; g < N_SPR; g++) begin : g_hit
    sprite_hit #(
      .COORD_W (COORD_W)
    ) u_hit (
      .dx    (s1_dx[g]),
      .dy    (s1_dy[g]),
      .s     (s1_s[g]),
      .mode  (spr_mode_t'(s1_mode[g])),
      .hit_c (hit_c[g])
    );
  end

  // Lowest-index active hit wins, otherwise background
  always_comb begin
    sel_c       = '{r: BG_R, g: BG_G, b: s1_bg_b};
    sel_found_c = 1'b0;
    for (int unsigned i = 0; i < N_SPR; i++) begin
      if (!sel_found_c && hit_c[i] && s1_act[i]) begin
        sel_c       = rgb_t'(s1_rgb[i]);
        sel_found_c = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_valid <= 1'b0;
      VGA_R     <= 8'h00;
      VGA_G     <= 8'h00;
      VGA_B     <= 8'h00;
    end else begin
      rgb_valid <= s1_valid;
      VGA_R     <= s1_valid ? sel_c.r : 8'h00;
      VGA_G     <= s1_valid ? sel_c.g : 8'h00;
      VGA_B     <= s1_valid ? sel_c.b : 8'h00;
    end
  end

endmodule

// File: tb/tb_layered_color_mapper.sv
// Directed scoreboard bench for layered_color_mapper with a fast blink period.
module tb_layered_color_mapper;

  localparam int unsigned NS = 4;
  localparam int unsigned CW = 10;
  localparam int unsigned BF = 2;

  logic                    Clk = 1'b0;
  logic                    Reset = 1'b0;
  logic                    frame_start = 1'b0;
  logic                    pix_valid = 1'b0;
  logic [CW-1:0]           DrawX = '0;
  logic [CW-1:0]           DrawY = '0;
  logic [NS-1:0][CW-1:0]   d_x = '0;
  logic [NS-1:0][CW-1:0]   d_y = '0;
  logic [NS-1:0][CW-1:0]   d_s = '0;
  logic [NS-1:0]           d_mode = '0;
  logic [NS-1:0]           d_en = '0;
  logic [NS-1:0]           d_blink = '0;
  logic [NS-1:0][23:0]     d_rgb = '0;
  logic [7:0]              VGA_R;
  logic [7:0]              VGA_G;
  logic [7:0]              VGA_B;
  logic                    rgb_valid;

  layered_color_mapper #(
    .N_SPR        (NS),
    .COORD_W      (CW),
    .BLINK_FRAMES (BF)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .spr_x       (d_x),
    .spr_y       (d_y),
    .spr_s       (d_s),
    .spr_mode    (d_mode),
    .spr_en      (d_en),
    .spr_blink   (d_blink),
    .spr_rgb     (d_rgb),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .rgb_valid   (rgb_valid)
  );

  always #5 Clk = ~Clk;

  typedef logic [24:0] exp_t;

  int          n_assert = 0;
  int          n_fail = 0;
  exp_t        q[$];
  string       tq[$];

  int          m_x[NS];
  int          m_y[NS];
  int          m_s[NS];
  bit          m_mode[NS];
  bit          m_en[NS];
  bit          m_blink[NS];
  logic [23:0] m_rgb[NS];
  int          m_cnt;
  bit          m_phase;

  function automatic exp_t model(input bit pv, input int x, input int y);
    int dx, dy;
    bit hit;
    if (!pv) return '0;
    for (int i = 0; i < NS; i++) begin
      if (m_en[i] && !(m_phase && m_blink[i])) begin
        dx = x - m_x[i];
        dy = y - m_y[i];
        if (m_mode[i]) hit = (dx * dx + dy * dy) <= (m_s[i] * m_s[i]);
        else           hit = (dx <= m_s[i]) && (-dx <= m_s[i]) && (dy <= m_s[i]) && (-dy <= m_s[i]);
        if (hit) return {1'b1, m_rgb[i]};
      end
    end
    return {1'b1, 8'h3F, 8'h00, 8'(8'h7F - (x >> (CW - 7)))};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NS; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_s[i] = 0;
      m_mode[i] = 0; m_en[i] = 0; m_blink[i] = 0; m_rgb[i] = '0;
    end
    m_cnt = 0;
    m_phase = 0;
    q.delete();
    tq.delete();
  endtask

  task automatic model_load();
    for (int i = 0; i < NS; i++) begin
      m_x[i] = int'(d_x[i]); m_y[i] = int'(d_y[i]); m_s[i] = int'(d_s[i]);
      m_mode[i] = d_mode[i]; m_en[i] = d_en[i]; m_blink[i] = d_blink[i];
      m_rgb[i] = d_rgb[i];
    end
    if (m_cnt == int'(BF) - 1) begin
      m_cnt = 0;
      m_phase = !m_phase;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check(input string tag, input exp_t got, input exp_t exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed v=%b rgb=%h expected v=%b rgb=%h", tag, got[24], got[23:0], exp[24], exp[23:0]);
    end
  endtask

  task automatic cfg(input int i, input int x, input int y, input int s, input bit circ,
                     input bit en, input bit blink, input logic [23:0] rgb);
    d_x[i] = CW'(x); d_y[i] = CW'(y); d_s[i] = CW'(s);
    d_mode[i] = circ; d_en[i] = en; d_blink[i] = blink; d_rgb[i] = rgb;
  endtask

  // Drive one cycle; expected result is queued and compared two edges later
  task automatic step(input bit fs, input bit pv, input int x, input int y, input string tag);
    exp_t e;
    string t;
    frame_start = fs;
    pix_valid = pv;
    DrawX = CW'(x);
    DrawY = CW'(y);
    q.push_back(model(pv, x, y));
    tq.push_back(tag);
    if (fs) model_load();
    @(posedge Clk);
    #1;
    if (q.size() >= 2) begin
      e = q.pop_front();
      t = tq.pop_front();
      check(t, {rgb_valid, VGA_R, VGA_G, VGA_B}, e);
    end
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    #1;
    check({tag, "_async"}, {rgb_valid, VGA_R, VGA_G, VGA_B}, '0);
    @(posedge Clk);
    #1;
    check({tag, "_hold"}, {rgb_valid, VGA_R, VGA_G, VGA_B}, '0);
    @(negedge Clk);
    Reset = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    #1;
    do_reset("rst_init");

    cfg(0, 100, 100, 8, 1'b0, 1'b1, 1'b0, 24'hFF0000);
    cfg(1, 200, 200, 5, 1'b1, 1'b1, 1'b0, 24'h00FF00);
    cfg(2,  50,  50, 4, 1'b0, 1'b1, 1'b0, 24'h0000FF);
    cfg(3,   0,   0, 2, 1'b0, 1'b1, 1'b0, 24'hFFFF00);
    step(1, 1, 100, 100, "fs_pix_old_shadow");
    step(0, 1, 108, 100, "sq_edge_x");
    step(0, 1, 109, 100, "sq_out_x");
    step(0, 1, 100,  92, "sq_edge_y");
    step(0, 1, 100,  91, "sq_out_y");
    step(0, 0, 100, 100, "pix_invalid");
    step(0, 1, 203, 204, "circ_in");
    step(0, 1, 204, 204, "circ_out");
    step(0, 1, 200, 205, "circ_edge");
    step(0, 1,  50,  50, "sq2_centre");
    step(0, 1,   2,   0, "corner_hit");
    step(0, 1, 1022,  0, "no_wrap_x");
    step(0, 1,   0, 1023, "no_wrap_y");
    step(0, 1, 1023, 1023, "bg_far_corner");

    // Shadow isolation: inputs change without frame_start
    cfg(0, 120, 100, 8, 1'b0, 1'b1, 1'b0, 24'hFF0000);
    step(0, 1, 108, 100, "no_fs_unchanged");
    step(1, 1, 108, 100, "fs_same_cycle_old");
    step(0, 1, 108, 100, "after_fs_new");
    step(0, 1, 120, 100, "moved_sprite");

    // Priority between overlapping sprites
    cfg(0, 50, 50, 3, 1'b0, 1'b1, 1'b0, 24'hFF0000);
    step(1, 0, 0, 0, "fs_overlap");
    step(0, 1, 50, 50, "overlap_red");
    cfg(0, 50, 50, 3, 1'b0, 1'b0, 1'b0, 24'hFF0000);
    step(1, 0, 0, 0, "fs_disable0");
    step(0, 1, 50, 50, "overlap_blue");

    // Zero size in both modes
    cfg(1, 200, 200, 0, 1'b1, 1'b1, 1'b0, 24'h00FF00);
    cfg(2,  50,  50, 0, 1'b0, 1'b1, 1'b0, 24'h0000FF);
    step(1, 0, 0, 0, "fs_zero_size");
    step(0, 1, 200, 200, "circ_s0_centre");
    step(0, 1, 200, 201, "circ_s0_off");
    step(0, 1,  50,  50, "sq_s0_centre");
    step(0, 1,  51,  50, "sq_s0_off");
    step(0, 0, 0, 0, "drain_a");
    step(0, 0, 0, 0, "drain_b");

    // Blinking over several frames from a known counter state
    do_reset("rst_blink");
    cfg(0, 100, 100, 8, 1'b0, 1'b1, 1'b1, 24'hFF0000);
    cfg(1, 300, 300, 4, 1'b1, 1'b1, 1'b0, 24'h00FF00);
    cfg(2,  50,  50, 4, 1'b0, 1'b0, 1'b0, 24'h0000FF);
    cfg(3,   0,   0, 2, 1'b0, 1'b0, 1'b0, 24'hFFFF00);
    for (int f = 0; f < 5; f++) begin
      step(1, 1, 100, 100, $sformatf("blink_fs_f%0d", f));
      step(0, 1, 100, 100, $sformatf("blink_spr_f%0d", f));
      step(0, 1, 300, 300, $sformatf("steady_spr_f%0d", f));
      step(0, 0, 0, 0, $sformatf("blink_gap_f%0d", f));
    end

    // Reset while valid pixels are in flight
    step(0, 1, 300, 300, "pre_rst_a");
    step(0, 1, 300, 301, "pre_rst_b");
    #2;
    do_reset("rst_stream");
    step(0, 1, 300, 300, "post_rst_bg_a");
    step(0, 1, 100, 100, "post_rst_bg_b");
    step(1, 1, 300, 300, "post_rst_fs");
    step(0, 1, 300, 300, "post_rst_visible");
    step(0, 0, 0, 0, "drain_c");
    step(0, 0, 0, 0, "drain_d");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
